// File: rtl/decoder_pkg.sv
// Shared types for the decoder/scan controller: FSM state encoding and mode constants.
package decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_SCAN = 2'd2
   } state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_scan_n_if.sv
// Select handshake between a line requester and the decoder/scan controller.
interface decoder_scan_n_if #(
   parameter int SEL_W = 2
);
   logic [SEL_W-1:0] sel;
   logic             sel_valid;
   logic             sel_ready;

   modport master (output sel, output sel_valid, input sel_ready);
   modport slave  (input sel, input sel_valid, output sel_ready);
endinterface

// File: rtl/onehot_dec.sv
// Binary index to one-hot line decode with selectable output polarity.
module onehot_dec #(
   parameter int SEL_W   = 2,
   parameter int ACT_LOW = 1
) (
   input  logic [SEL_W-1:0]      idx,
   input  logic                  active,
   output logic [(2**SEL_W)-1:0] lines
);
   localparam int N = 2**SEL_W;

   logic hot;

   always_comb begin
      lines = '0;
      hot   = 1'b0;
      for (int i = 0; i < N; i++) begin
         hot      = active && (idx == SEL_W'(i));
         lines[i] = (ACT_LOW != 0) ? ~hot : hot;
      end
   end
endmodule

// File: rtl/decoder_scan_n.sv
// Decoder with direct (handshaked select) and auto-scan modes over 2**SEL_W lines.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | no line active, waiting for a select or scan mode
// HOLD    | latched line idx_q held active
// SCAN    | stepping through lines, each held dwell+1 cycles
module decoder_scan_n
   import decoder_pkg::*;
#(
   parameter int SEL_W   = 2,
   parameter int DWELL_W = 8,
   parameter int ACT_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en_n,
   input  logic                  mode,
   input  logic [DWELL_W-1:0]    dwell,
   decoder_scan_n_if.slave       sel_if,
   output logic [(2**SEL_W)-1:0] d_out,
   output logic                  busy,
   output logic                  wrap
);
   state_t             state_q, state_d;
   logic [SEL_W-1:0]   idx_q, idx_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [DWELL_W-1:0] dwell_eff;
   logic               wrap_q, wrap_d;
   logic               line_on;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         dwell_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         dwell_q <= dwell_d;
         wrap_q  <= wrap_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      idx_d            = idx_q;
      cnt_d            = cnt_q;
      dwell_d          = dwell_q;
      wrap_d           = 1'b0;
      sel_if.sel_ready = 1'b0;
      // A line's dwell is taken live on its first cycle, then frozen for the rest of it.
      dwell_eff        = (cnt_q == '0) ? dwell : dwell_q;

      if (en_n) begin
         state_d = ST_IDLE;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_HOLD: begin
               sel_if.sel_ready = (mode == MODE_DIRECT);
               if (mode == MODE_SCAN) begin
                  state_d = ST_SCAN;
                  idx_d   = '0;
                  cnt_d   = '0;
               end else if (sel_if.sel_valid) begin
                  state_d = ST_HOLD;
                  idx_d   = sel_if.sel;
               end
            end
            ST_SCAN: begin
               if (mode == MODE_DIRECT) begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
                  cnt_d   = '0;
               end else begin
                  dwell_d = dwell_eff;
                  if (cnt_q == dwell_eff) begin
                     cnt_d  = '0;
                     idx_d  = idx_q + SEL_W'(1);
                     wrap_d = (idx_q == '1);
                  end else begin
                     cnt_d = cnt_q + DWELL_W'(1);
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // en_n gates the lines combinationally so they drop in the same cycle it rises.
   assign line_on = !en_n && (state_q != ST_IDLE);
   assign busy    = (state_q == ST_SCAN);
   assign wrap    = wrap_q;

   onehot_dec #(
      .SEL_W   (SEL_W),
      .ACT_LOW (ACT_LOW)
   ) u_dec (
      .idx    (idx_q),
      .active (line_on),
      .lines  (d_out)
   );
endmodule

// File: tb/tb_decoder_scan_n.sv
// Bench for decoder_scan_n: 4-line and 8-line instances on shared stimulus, checked per cycle.
module tb_decoder_scan_n;
   localparam int P_IDLE = 0;
   localparam int P_HOLD = 1;
   localparam int P_SCAN = 2;

   logic       clk = 1'b0;
   logic       rst_n, en_n, mode, sel_valid;
   logic [2:0] sel3;
   logic [7:0] dwell;
   logic [3:0] d_out0;
   logic       busy0, wrap0;
   logic [7:0] d_out1;
   logic       busy1, wrap1;

   int n_chk = 0;
   int n_err = 0;

   decoder_scan_n_if #(.SEL_W(2)) if0 ();
   decoder_scan_n_if #(.SEL_W(3)) if1 ();

   assign if0.sel       = sel3[1:0];
   assign if0.sel_valid = sel_valid;
   assign if1.sel       = sel3;
   assign if1.sel_valid = sel_valid;

   decoder_scan_n #(.SEL_W(2), .DWELL_W(8), .ACT_LOW(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .en_n(en_n), .mode(mode), .dwell(dwell),
      .sel_if(if0), .d_out(d_out0), .busy(busy0), .wrap(wrap0)
   );

   decoder_scan_n #(.SEL_W(3), .DWELL_W(8), .ACT_LOW(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .en_n(en_n), .mode(mode), .dwell(dwell),
      .sel_if(if1), .d_out(d_out1), .busy(busy1), .wrap(wrap1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
      chk(name, {4'h0, act}, {4'h0, exp});
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {7'h0, act}, {7'h0, exp});
   endtask

   // Behavioural model: phase, active line, cycles left on the line, wrap flag.
   int ph[2], ln[2], left[2];
   bit fresh[2], mw[2];
   int nl[2] = '{4, 8};

   task automatic model_step(input int k);
      if (en_n) begin
         ph[k] = P_IDLE;
         mw[k] = 1'b0;
      end else if (ph[k] != P_SCAN) begin
         mw[k] = 1'b0;
         if (mode) begin
            ph[k] = P_SCAN; ln[k] = 0; fresh[k] = 1'b1;
         end else if (sel_valid) begin
            ph[k] = P_HOLD; ln[k] = int'(sel3) % nl[k];
         end
      end else if (!mode) begin
         ph[k] = P_IDLE;
         mw[k] = 1'b0;
      end else begin
         if (fresh[k]) begin
            left[k]  = int'(dwell);
            fresh[k] = 1'b0;
         end
         if (left[k] == 0) begin
            mw[k]    = (ln[k] == nl[k] - 1);
            ln[k]    = (ln[k] + 1) % nl[k];
            fresh[k] = 1'b1;
         end else begin
            left[k] = left[k] - 1;
            mw[k]   = 1'b0;
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            ph[k] = P_IDLE; ln[k] = 0; left[k] = 0; fresh[k] = 1'b0; mw[k] = 1'b0;
         end else begin
            model_step(k);
         end
      end
   end

   function automatic logic [7:0] exp_lines(input int k);
      logic [7:0] v;
      v = 8'h00;
      if (!en_n && ph[k] != P_IDLE) v = 8'h01 << ln[k];
      v = ~v;
      if (k == 0) v = v & 8'h0F;
      return v;
   endfunction

   logic exp_rdy0, exp_rdy1;

   always @(negedge clk) begin
      exp_rdy0 = !en_n && !mode && (ph[0] != P_SCAN);
      exp_rdy1 = !en_n && !mode && (ph[1] != P_SCAN);
      chk("m_dout0", {4'h0, d_out0}, exp_lines(0));
      chk("m_dout1", d_out1, exp_lines(1));
      chk1("m_busy0", busy0, ph[0] == P_SCAN);
      chk1("m_busy1", busy1, ph[1] == P_SCAN);
      chk1("m_wrap0", wrap0, mw[0]);
      chk1("m_wrap1", wrap1, mw[1]);
      chk1("m_ready0", if0.sel_ready, exp_rdy0);
      chk1("m_ready1", if1.sel_ready, exp_rdy1);
      chk1("onehot1", ($countones(~d_out1) <= 1), 1'b1);
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      #3;
   endtask

   task automatic wait_wrap(input int k);
      int i;
      i = 0;
      while (i < 60 && !((k == 0) ? wrap0 : wrap1)) begin
         nxt();
         i++;
      end
      chk1("wrap_wait", (k == 0) ? wrap0 : wrap1, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; en_n = 1'b1; mode = 1'b0; sel_valid = 1'b0; sel3 = 3'd0; dwell = 8'd0;
      repeat (3) nxt();
      look();
      chk4("rst_dout", d_out0, 4'b1111);
      chk1("rst_busy", busy0, 1'b0);
      chk1("rst_wrap", wrap0, 1'b0);

      nxt(); rst_n = 1'b1; en_n = 1'b0;

      // direct decode, back-to-back transfers
      nxt(); sel3 = 3'd2; sel_valid = 1'b1; look();
      chk1("ready_direct", if0.sel_ready, 1'b1);
      nxt(); sel_valid = 1'b0; look();
      chk4("direct_sel2", d_out0, 4'b1011);
      nxt(); sel3 = 3'd0; sel_valid = 1'b1; look();
      chk4("direct_hold", d_out0, 4'b1011);
      nxt(); sel_valid = 1'b0; look();
      chk4("direct_sel0", d_out0, 4'b1110);

      // enable pulse during HOLD at line 3
      nxt(); sel3 = 3'd3; sel_valid = 1'b1;
      nxt(); sel_valid = 1'b0; look();
      chk4("hold3", d_out0, 4'b0111);
      nxt(); en_n = 1'b1; look();
      chk4("en_off", d_out0, 4'b1111);
      nxt(); en_n = 1'b0; look();
      chk4("idle_after_en", d_out0, 4'b1111);
      nxt(); look();
      chk4("idle_stays", d_out0, 4'b1111);
      nxt(); sel3 = 3'd1; sel_valid = 1'b1; look();
      chk4("idle_pre_xfer", d_out0, 4'b1111);
      nxt(); sel_valid = 1'b0; look();
      chk4("retransfer", d_out0, 4'b1101);

      // scan with dwell=2
      nxt(); mode = 1'b1; dwell = 8'd2; look();
      chk1("ready_scan_req", if0.sel_ready, 1'b0);
      nxt(); look();
      chk4("scan_entry", d_out0, 4'b1110);
      chk1("scan_busy", busy0, 1'b1);
      wait_wrap(0);
      for (int j = 0; j < 12; j++) begin
         look();
         chk4("scan_seq", d_out0, ~(4'b0001 << (j / 3)));
         chk1("scan_wrap", wrap0, j == 0);
         nxt();
      end
      look();
      chk1("wrap_period12", wrap0, 1'b1);
      chk4("wrap_line0", d_out0, 4'b1110);

      // mode exit with a pending select
      nxt(); mode = 1'b0; sel3 = 3'd2; sel_valid = 1'b1; look();
      chk1("exit_ready0", if0.sel_ready, 1'b0);
      chk1("exit_busy", busy0, 1'b1);
      nxt(); look();
      chk1("exit_idle_busy", busy0, 1'b0);
      chk4("exit_idle_dout", d_out0, 4'b1111);
      chk1("exit_ready1", if0.sel_ready, 1'b1);
      nxt(); sel_valid = 1'b0; look();
      chk4("exit_accept", d_out0, 4'b1011);

      // 8 lines, dwell=0
      nxt(); mode = 1'b1; dwell = 8'd0;
      nxt();
      wait_wrap(1);
      for (int j = 0; j < 8; j++) begin
         look();
         chk("scan8_seq", d_out1, ~(8'h01 << j));
         chk1("scan8_wrap", wrap1, j == 0);
         nxt();
      end
      look();
      chk1("wrap_period8", wrap1, 1'b1);

      // reset in the middle of a scan, on a wrap cycle
      nxt();
      wait_wrap(0);
      rst_n = 1'b0; #1;
      chk4("rst_scan_dout", d_out0, 4'b1111);
      chk("rst_scan_dout1", d_out1, 8'hFF);
      chk1("rst_scan_busy", busy0, 1'b0);
      chk1("rst_scan_wrap", wrap0, 1'b0);
      nxt(); nxt(); rst_n = 1'b1; mode = 1'b0;
      nxt(); sel3 = 3'd1; sel_valid = 1'b1;
      nxt(); sel_valid = 1'b0; look();
      chk4("post_rst_xfer", d_out0, 4'b1101);

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         nxt();
         rst_n     = ($urandom_range(0, 199) != 0);
         en_n      = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 19) == 0) mode = ~mode;
         sel_valid = 1'($urandom_range(0, 1));
         sel3      = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) dwell = 8'($urandom_range(0, 3));
      end
      nxt();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/decoder_scan_n.md
DECODER_SCAN_N -- requirements
Module: decoder_scan_n

Interface
REQ-001 The block SHALL have parameter SEL_W, default 2, meaning select width; the output count is N = 2**SEL_W.
REQ-002 The block SHALL have parameter DWELL_W, default 8, meaning the width of the scan dwell counter.
REQ-003 The block SHALL have parameter ACT_LOW, default 1, meaning the output polarity: 1 = selected line low, others high; 0 = inverted.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en_n  input  1  active-low enable; when high, all outputs are inactive.
REQ-007 mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-008 sel  input  SEL_W  select value for direct mode.
REQ-009 sel_valid  input  1  sel is presented this cycle.
REQ-010 sel_ready  output  1  the block accepts sel this cycle.
REQ-011 dwell  input  DWELL_W  number of extra cycles each line stays active in scan mode.
REQ-012 d_out  output  N  decoded one-hot lines, polarity per ACT_LOW.
REQ-013 busy  output  1  high while in the SCAN state.
REQ-014 wrap  output  1  one-cycle pulse when the scan index wraps from N-1 to 0.

Function
REQ-015 The FSM SHALL have three states: IDLE (no line active), HOLD (latched line active), SCAN (stepping).
REQ-016 sel_ready SHALL be 1 only when en_n=0, mode=0, and the state is IDLE or HOLD.
REQ-017 A transfer (sel_valid & sel_ready) SHALL latch sel into the index and enter HOLD, with the decoded line on d_out exactly one cycle after the transfer edge (latency 1).
REQ-018 HOLD SHALL keep the line active until the next transfer (new line, latency 1, no inactive gap) or until en_n rises.
REQ-019 In IDLE or HOLD with en_n=0 and mode=1, the FSM SHALL enter SCAN with index 0 and dwell counter 0.
REQ-020 In SCAN, line[index] SHALL be active for exactly dwell+1 cycles; the index then SHALL increment.
REQ-021 The index SHALL wrap from N-1 to 0, asserting wrap for one cycle coincident with the first cycle of line 0.
REQ-022 dwell SHALL be sampled when each line starts; changes mid-dwell SHALL take effect on the next line.
REQ-023 dwell=0 SHALL step one line per cycle.
REQ-024 mode falling to 0 during SCAN SHALL return the FSM to IDLE on the next edge, with all lines inactive; sel_valid in that cycle SHALL be ignored (sel_ready=0).
REQ-025 en_n=1 SHALL force all d_out lines inactive combinationally in the same cycle, and SHALL send the FSM to IDLE with the index cleared to 0 on the next edge.
REQ-026 At most one d_out line SHALL be active in any cycle.
REQ-027 Counter arithmetic SHALL be unsigned modulo its width, with no saturation.

Reset
REQ-028 rst_n low SHALL immediately set state=IDLE, index=0, dwell counter=0, wrap=0, busy=0, and all d_out inactive (all 1 when ACT_LOW=1).
REQ-029 Reset deassertion SHALL take effect on the first rising clk edge after rst_n goes high; no transfer SHALL be lost or duplicated across reset.

Structure
REQ-030 The state encoding enum and the mode constants (MODE_DIRECT=0, MODE_SCAN=1) SHALL reside in package decoder_pkg.
REQ-031 The binary-to-one-hot conversion with polarity SHALL be a sub-module, onehot_dec, parametrised by SEL_W and ACT_LOW; all sequencing stays in decoder_scan_n.

Verification
REQ-032 Reset test: SEL_W=2, ACT_LOW=1, rst_n low mid-SCAN -> d_out=4'b1111, busy=0, wrap=0 immediately.
REQ-033 Direct test: mode=0, en_n=0, sel=2'd2 with sel_valid -> d_out=4'b1011 one cycle later, held; then sel=2'd0 -> 4'b1110 the next cycle, with no all-high gap.
REQ-034 Scan test: mode=1, dwell=2 -> each line low for 3 cycles in order 0,1,2,3,0; wrap high for exactly 1 cycle at the return to line 0 (every 12 cycles).
REQ-035 Enable test: en_n pulsed high for 1 cycle during HOLD at line 3 -> d_out=4'b1111 that cycle, then IDLE (no line active) until a new transfer.
REQ-036 Boundary test: dwell=0 with SEL_W=3 -> 8 lines cycled one per cycle; wrap every 8 cycles; a one-hot check holds for every cycle.
REQ-037 Mode-exit test: mode dropped in SCAN with sel_valid=1 -> sel_ready=0 that cycle, IDLE next cycle, then sel accepted one cycle later.
